// File: rtl/rbt_s_parser_port_arbiter.sv
// rbt_s_parser_port_arbiter
// Frame-level round-robin arbiter feeding the rbt_s parser header-extract input.
// One port owns the merged stream from its first beat through tlast. Every
// forwarded beat carries its source port index in tuser. The merged stream is
// driven through a two-entry registered skid stage.
module rbt_s_parser_port_arbiter #(
  parameter int PORTS          = 4,
  parameter int DATA_WIDTH     = 512,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int USER_WIDTH     = 64,
  parameter int PORT_ID_OFFSET = 0,
  parameter int PORT_W         = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  output logic [PORTS-1:0]            s_axis_tready,
  input  logic [PORTS-1:0]            s_axis_tlast,
  input  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [USER_WIDTH-1:0]       m_axis_tuser,

  input  logic [PORTS-1:0]            port_enable,
  output logic                        grant_valid,
  output logic [PORT_W-1:0]           grant_port
);

  localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t              state;
  logic [PORT_W-1:0]   rr_ptr;
  logic [PORT_W-1:0]   grant_port_q;

  logic [PORTS-1:0]    req;
  logic                found;
  logic [PORT_W-1:0]   winner;
  logic [PORT_W-1:0]   rr_next;
  int unsigned         idx;

  logic [PORT_W-1:0]   sel_port;
  logic                in_valid;
  logic                in_last;
  logic                in_acc;
  logic [DATA_WIDTH-1:0] in_data;
  logic [KEEP_WIDTH-1:0] in_keep;
  logic [USER_WIDTH-1:0] in_user;
  logic [BEAT_W-1:0]   in_beat;

  logic                stage_ready;
  logic                skid_valid;
  logic [BEAT_W-1:0]   skid_beat;

  assign req = s_axis_tvalid & port_enable;

  // Circular first-set search over the request vector starting at rr_ptr.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      idx = (32'(rr_ptr) + k) % PORTS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PORT_W'(idx);
      end
    end
  end

  assign rr_next = (winner == PORT_W'(PORTS - 1)) ? '0 : winner + 1'b1;

  // Source mux: the locked port while a frame is open, otherwise the winner.
  always_comb begin
    sel_port = (state == LOCK) ? grant_port_q : winner;
    in_valid = (state == LOCK) ? s_axis_tvalid[grant_port_q] : found;
    in_last  = s_axis_tlast[sel_port];
    in_data  = s_axis_tdata[32'(sel_port)*DATA_WIDTH +: DATA_WIDTH];
    in_keep  = s_axis_tkeep[32'(sel_port)*KEEP_WIDTH +: KEEP_WIDTH];
    in_user  = s_axis_tuser[32'(sel_port)*USER_WIDTH +: USER_WIDTH];
    in_user[PORT_ID_OFFSET +: PORT_W] = sel_port;
    in_beat  = {in_data, in_keep, in_last, in_user};
  end

  assign in_acc = in_valid & stage_ready;

  // Only the selected port may see ready; everyone else is held off.
  always_comb begin
    s_axis_tready           = '0;
    s_axis_tready[sel_port] = stage_ready & ((state == LOCK) | found);
  end

  assign grant_valid = (state == LOCK) | in_acc;
  assign grant_port  = ((state == IDLE) && in_acc) ? winner : grant_port_q;

  // Frame lock FSM and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_port_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_acc) begin
            grant_port_q <= winner;
            rr_ptr       <= rr_next;
            if (!in_last) begin
              state <= LOCK;
            end
          end
        end
        LOCK: begin
          if (in_acc && in_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register plus skid entry; input ready is a flop that is low
  // exactly while the skid entry holds a beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      skid_valid    <= 1'b0;
      skid_beat     <= '0;
      stage_ready   <= 1'b0;
    end else if (!m_axis_tvalid || m_axis_tready) begin
      stage_ready <= 1'b1;
      if (skid_valid) begin
        m_axis_tvalid <= 1'b1;
        {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} <= skid_beat;
        skid_valid    <= 1'b0;
      end else begin
        m_axis_tvalid <= in_acc;
        if (in_acc) begin
          {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} <= in_beat;
        end
      end
    end else if (in_acc) begin
      skid_valid  <= 1'b1;
      skid_beat   <= in_beat;
      stage_ready <= 1'b0;
    end else begin
      stage_ready <= !skid_valid;
    end
  end

endmodule
